// File: rtl/regfl_rd_pkg.sv
// regfl_rd_pkg: shared state encoding and default sizes for the register-file chunk reader
package regfl_rd_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int W_DEF      = 3;
  localparam int RGST_W_DEF = 64;
  localparam int CW_DEF     = 8;
endpackage

// File: rtl/regfl_mux.sv
// regfl_mux: combinational selection of one register out of the flattened register file
module regfl_mux
  import regfl_rd_pkg::*;
#(
  parameter int w      = W_DEF,
  parameter int rgst_w = RGST_W_DEF
) (
  input  logic [(2**w)*rgst_w-1:0] q,
  input  logic [w-1:0]             s,
  output logic [rgst_w-1:0]        rd
);
  logic [rgst_w-1:0] regs [2**w];
  // register 0 sits in the top slice of q
  for (genvar i = 0; i < 2**w; i++) begin : g_reg
    assign regs[i] = q[(2**w-i)*rgst_w-1 -: rgst_w];
  end
  assign rd = regs[s];
endmodule

// File: rtl/regfl_rd.sv
// regfl_rd: snapshots one register on request and streams it out MSB-first in cw-bit chunks
module regfl_rd
  import regfl_rd_pkg::*;
#(
  parameter int w      = W_DEF,
  parameter int rgst_w = RGST_W_DEF,
  parameter int cw     = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [(2**w)*rgst_w-1:0] q,
  input  logic                     req,
  input  logic [w-1:0]             s,
  output logic                     busy,
  output logic [cw-1:0]            dout,
  output logic                     dvld,
  input  logic                     drdy,
  output logic                     dlast
);
  localparam int NB    = rgst_w / cw;
  localparam int CNT_W = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);
  state_t state, state_nx;
  logic [rgst_w-1:0] sr, rd;
  logic [CNT_W-1:0] cnt;
  logic fire, done;
  regfl_mux #(.w(w), .rgst_w(rgst_w)) u_mux (.q(q), .s(s), .rd(rd));
  assign fire = state == SEND && drdy;
  assign done = fire && cnt == LAST;
  always_comb state_nx = state == IDLE ? (req ? SEND : IDLE) : (done ? IDLE : SEND);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        sr  <= rd;
        cnt <= '0;
      end else if (fire) begin
        sr  <= sr << cw;
        cnt <= done ? cnt : cnt + 1'b1;
      end
    end
  end
  assign busy  = state == SEND;
  assign dvld  = busy;
  assign dlast = busy && cnt == LAST;
  assign dout  = busy ? sr[rgst_w-1 -: cw] : '0;
endmodule

// File: tb/tb_regfl_rd.sv
// tb_regfl_rd: scoreboard bench for regfl_rd with default sizes (8 x 64-bit registers, 8-bit chunks)
module tb_regfl_rd;
  logic         clk = 0;
  logic         rst_b;
  logic [511:0] q;
  logic         req;
  logic [2:0]   s;
  logic         busy;
  logic [7:0]   dout;
  logic         dvld;
  logic         drdy;
  logic         dlast;
  logic [63:0]  regs [8];
  typedef struct {logic [7:0] d; logic l;} beat_t;
  beat_t exp_q [$];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  regfl_rd dut (
    .clk(clk), .rst_b(rst_b), .q(q), .req(req), .s(s), .busy(busy),
    .dout(dout), .dvld(dvld), .drdy(drdy), .dlast(dlast)
  );

  always #5 clk = ~clk;

  always_comb begin
    q = '0;
    for (int i = 0; i < 8; i++) q[(8-i)*64-1 -: 64] = regs[i];
  end

  task automatic start(input int sel);
    beat_t b;
    @(negedge clk);
    req = 1;
    s   = 3'(sel);
    for (int k = 0; k < 8; k++) begin
      b.d = regs[sel][63-8*k -: 8];
      b.l = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rst_b = 0; req = 0; s = 0; drdy = 1;
    repeat (2) @(negedge clk);
    tot_cnt++;
    if ({busy, dvld, dlast, dout} !== 11'd0)
      $display("FAIL reset_hold: busy=%b dvld=%b dlast=%b dout=%h want all 0", busy, dvld, dlast, dout);
    else pass_cnt++;
    rst_b = 1;
    repeat (2) @(negedge clk);
    tot_cnt++;
    if ({busy, dvld, dlast, dout} !== 11'd0)
      $display("FAIL idle_after_reset: busy=%b dvld=%b dlast=%b dout=%h want all 0", busy, dvld, dlast, dout);
    else pass_cnt++;
  endtask

  task automatic test_basic(input int sel, input string name);
    int hs = 0;
    drdy = 1;
    start(sel);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 0;
      if (!dvld) break;
      tot_cnt++;
      if (exp_q.size() == 0)
        $display("FAIL %s_extra_beat: dout=%h want no beat", name, dout);
      else if (dout !== exp_q[0].d || dlast !== exp_q[0].l || busy !== 1'b1)
        $display("FAIL %s_beat%0d: dout=%h dlast=%b busy=%b want dout=%h dlast=%b busy=1",
                 name, hs, dout, dlast, busy, exp_q[0].d, exp_q[0].l);
      else pass_cnt++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      hs++;
    end
    tot_cnt++;
    if (hs != 8 || busy !== 1'b0 || dout !== 8'd0)
      $display("FAIL %s_end: beats=%0d busy=%b dout=%h want beats=8 busy=0 dout=00", name, hs, busy, dout);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int hs = 0;
    logic [7:0] pd;
    logic pl;
    logic prdy = 1;
    start(1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      req = 0;
      if (!dvld) break;
      tot_cnt++;
      if (exp_q.size() == 0 || dout !== exp_q[0].d || dlast !== exp_q[0].l)
        $display("FAIL bp_beat%0d: dout=%h dlast=%b want dout=%h dlast=%b",
                 hs, dout, dlast, exp_q.size() ? exp_q[0].d : 8'hxx, exp_q.size() ? exp_q[0].l : 1'bx);
      else pass_cnt++;
      if (c > 0 && !prdy) begin
        tot_cnt++;
        if (dout !== pd || dlast !== pl)
          $display("FAIL bp_hold: dout=%h dlast=%b want held dout=%h dlast=%b", dout, dlast, pd, pl);
        else pass_cnt++;
      end
      pd = dout; pl = dlast;
      drdy = (c % 3 == 0);
      prdy = drdy;
      if (drdy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs++;
      end
    end
    tot_cnt++;
    if (hs != 8 || exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL bp_handshakes: got=%0d left=%0d busy=%b want 8 0 0", hs, exp_q.size(), busy);
    else pass_cnt++;
    exp_q.delete();
    drdy = 1;
  endtask

  task automatic test_q_change();
    int hs = 0;
    drdy = 1;
    start(2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 0;
      if (!dvld) break;
      tot_cnt++;
      if (exp_q.size() == 0 || dout !== exp_q[0].d || dlast !== exp_q[0].l)
        $display("FAIL qchg_beat%0d: dout=%h dlast=%b want dout=%h", hs, dout, dlast,
                 exp_q.size() ? exp_q[0].d : 8'hxx);
      else pass_cnt++;
      if (hs == 0) for (int i = 0; i < 8; i++) regs[i] = '0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      hs++;
    end
    tot_cnt++;
    if (hs != 8) $display("FAIL qchg_count: beats=%0d want 8", hs);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_req_ignore();
    int hs = 0;
    drdy = 1;
    start(3);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 0;
      if (!dvld) break;
      tot_cnt++;
      if (exp_q.size() == 0 || dout !== exp_q[0].d || dlast !== exp_q[0].l)
        $display("FAIL ign_beat%0d: dout=%h dlast=%b want dout=%h", hs, dout, dlast,
                 exp_q.size() ? exp_q[0].d : 8'hxx);
      else pass_cnt++;
      if (hs == 4 || dlast) begin req = 1; s = 3'd5; end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      hs++;
    end
    tot_cnt++;
    if (hs != 8) $display("FAIL ign_count: beats=%0d want 8", hs);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tot_cnt++;
      if (busy !== 1'b0 || dvld !== 1'b0)
        $display("FAIL ign_no_second_xfer: busy=%b dvld=%b want 0 0", busy, dvld);
      else pass_cnt++;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    drdy = 1;
    start(0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 0;
      if (!dvld) break;
      tot_cnt++;
      if (exp_q.size() == 0 || dout !== exp_q[0].d)
        $display("FAIL rstmid_beat%0d: dout=%h want %h", hs, dout, exp_q.size() ? exp_q[0].d : 8'hxx);
      else pass_cnt++;
      if (hs == 3) begin
        rst_b = 0;
        #1;
        tot_cnt++;
        if ({busy, dvld, dlast, dout} !== 11'd0)
          $display("FAIL rstmid_async: busy=%b dvld=%b dlast=%b dout=%h want all 0", busy, dvld, dlast, dout);
        else pass_cnt++;
        break;
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      hs++;
    end
    exp_q.delete();
    @(negedge clk);
    rst_b = 1;
    @(negedge clk);
    tot_cnt++;
    if (busy !== 1'b0 || dvld !== 1'b0)
      $display("FAIL rstmid_aborted: busy=%b dvld=%b want 0 0", busy, dvld);
    else pass_cnt++;
    test_basic(0, "post_rst");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = {$urandom, $urandom};
    regs[0] = 64'h0123456789ABCDEF;
    regs[7] = 64'hFEDCBA9876543210;
    regs[1] = 64'h1122334455667788;
    regs[2] = 64'hA5A55A5AC3C33C3C;
    regs[3] = 64'h0F1E2D3C4B5A6978;
    regs[5] = 64'hDEADBEEFCAFEF00D;
    test_reset();
    test_basic(0, "reg0");
    test_basic(7, "reg7");
    test_backpressure();
    test_req_ignore();
    test_q_change();
    regs[0] = 64'h0123456789ABCDEF;
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/regfl_rd.md
REGFL_RD -- requirements
Module: regfl_rd

Interface
REQ-001 The block SHALL have parameter w, default 3, meaning register-address width (2**w registers).
REQ-002 The block SHALL have parameter rgst_w, default 64, meaning register width in bits.
REQ-003 The block SHALL have parameter cw, default 8, meaning output chunk width; rgst_w SHALL be an integer multiple of cw.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_b.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst_b: input, 1 bit, asynchronous active-low reset.
REQ-007 Port q: input, 2**w*rgst_w bits, flattened register-file contents; register i occupies q[(2**w-i)*rgst_w-1 : (2**w-i-1)*rgst_w], so register 0 is the top slice.
REQ-008 Port req: input, 1 bit, read request, sampled only when idle.
REQ-009 Port s: input, w bits, register address qualified by req.
REQ-010 Port busy: output, 1 bit, transfer in progress.
REQ-011 Port dout: output, cw bits, current chunk.
REQ-012 Port dvld: output, 1 bit, dout valid.
REQ-013 Port drdy: input, 1 bit, consumer ready.
REQ-014 Port dlast: output, 1 bit, marks the final chunk of a register.

Function
REQ-015 The FSM SHALL have two states, IDLE and SEND; busy SHALL be 1 exactly in SEND.
REQ-016 In IDLE, req=1 at a rising edge SHALL snapshot register s from q into an internal rgst_w-bit shift register, clear the beat counter and enter SEND.
REQ-017 dvld SHALL be 1 in the first cycle after the capturing edge (one-cycle latency) and SHALL remain 1 throughout SEND.
REQ-018 Chunks SHALL be emitted MSB first: beat k carries snapshot bits [rgst_w-1-k*cw : rgst_w-(k+1)*cw].
REQ-019 A beat completes on an edge with dvld=1 and drdy=1; only then SHALL the shift register advance by cw and the counter increment.
REQ-020 While drdy=0, dout, dlast and dvld SHALL hold their values.
REQ-021 dlast SHALL be 1 only during beat rgst_w/cw-1; completion of that beat SHALL return the FSM to IDLE, with dvld=0 in the following cycle.
REQ-022 Changes on q after the capturing edge SHALL NOT affect the chunks emitted.
REQ-023 req in SEND, including the cycle of the last beat, SHALL be ignored; no request queueing.
REQ-024 In IDLE, dout SHALL be 0 and dvld and dlast SHALL be 0.
REQ-025 The beat counter SHALL be clog2(rgst_w/cw) bits wide, minimum 1, and SHALL never wrap within a transfer.

Reset
REQ-026 When rst_b=0, the block SHALL asynchronously force state IDLE, counter 0, shift register 0, busy 0, dvld 0, dlast 0 and dout 0.
REQ-027 Reset during SEND SHALL abort the transfer with no further beats; after reset releases, the next transfer starts at beat 0.

Structure
REQ-028 The state encoding for IDLE and SEND and the default values of w, rgst_w and cw SHALL be placed in the shared data-path package.
REQ-029 Register selection from q SHALL be a separate combinational sub-module, regfl_mux (parameters w and rgst_w), instanced once.

Verification
REQ-030 With w=3, rgst_w=64, cw=8, q slice of register 0 = 64'h0123456789ABCDEF and drdy=1, a one-cycle req with s=0 -> dvld high for 8 consecutive cycles, dout 01,23,45,67,89,AB,CD,EF, dlast only with EF, busy low afterwards.
REQ-031 With register 7 (q[63:0]) = 64'hFEDCBA9876543210 and s=7 -> dout FE,DC,...,10 in that order.
REQ-032 With drdy toggling 1,0,0,1,... -> dout and dlast held during the 0 cycles, no chunk lost or repeated, exactly 8 handshakes.
REQ-033 Overwriting all of q with 0 one cycle after capture -> original 8 chunks still emitted unchanged.
REQ-034 req with s=3, then s=5 pulsed during beat 4 and again on the dlast cycle -> only register 3 transferred, busy drops, no second transfer.
REQ-035 rst_b driven low during beat 3 -> dvld, dlast, busy and dout immediately 0; after release, req with s=0 -> full transfer starting at 01.
